// File: rtl/pid_out_clamp_frame_pkg.sv
// Shared FP64 helpers for the PID output limiter stages: constants, an order key and a NaN test.
// The NaN macro lives at file scope so every file that imports the package can use it.
`ifndef FP64_IS_NAN
`define FP64_IS_NAN(x) ((x[62:52] == 11'h7FF) && (x[51:0] != 52'h0))
`endif

package pid_out_clamp_frame_pkg;

  typedef logic [63:0] fp64_t;

  localparam fp64_t FP64_ONE  = 64'h3FF0_0000_0000_0000;
  localparam fp64_t FP64_ZERO = 64'h0000_0000_0000_0000;

  // Maps a double onto an unsigned key whose ordering matches the numeric ordering (-0.0 < +0.0).
  function automatic fp64_t fp64_key(input fp64_t x);
    fp64_key = x[63] ? ~x : {1'b1, x[62:0]};
  endfunction

endpackage

// File: rtl/pid_out_clamp_frame_fp64_clamp.sv
// Two-stage FP64 limiter: stage 1 registers the sample and its order key, stage 2 selects
// the sample or a limit and flags which side saturated. NaN always goes to LIM_LO.
module fp64_clamp
  import pid_out_clamp_frame_pkg::*;
#(
  parameter int unsigned      WIDTH  = 64,
  parameter logic [WIDTH-1:0] LIM_HI = FP64_ONE,
  parameter logic [WIDTH-1:0] LIM_LO = FP64_ZERO
) (
  input  logic             clk,
  input  logic             rst_user,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_x,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_y,
  output logic             out_hi,
  output logic             out_lo
);

  localparam fp64_t KEY_HI = fp64_key(LIM_HI);
  localparam fp64_t KEY_LO = fp64_key(LIM_LO);

  logic             vld1_r;
  logic [WIDTH-1:0] x1_r;
  fp64_t            key1_r;
  logic             nan1_r;
  logic [WIDTH-1:0] sel_y_s;
  logic             sel_hi_s;
  logic             sel_lo_s;
  logic             vld2_r;
  logic [WIDTH-1:0] y2_r;
  logic             hi2_r;
  logic             lo2_r;

  // Stage 1: capture sample, valid, order key and NaN class.
  always_ff @(posedge clk or posedge rst_user) begin
    if (rst_user) begin
      vld1_r <= 1'b0;
      x1_r   <= {WIDTH{1'b0}};
      key1_r <= 64'h0;
      nan1_r <= 1'b0;
    end else begin
      vld1_r <= in_vld;
      x1_r   <= in_x;
      key1_r <= fp64_key(in_x);
      nan1_r <= `FP64_IS_NAN(in_x);
    end
  end

  // Stage 2 select: NaN is checked first because a positive NaN keys above every number.
  always_comb begin
    sel_y_s  = x1_r;
    sel_hi_s = 1'b0;
    sel_lo_s = 1'b0;
    if (nan1_r) begin
      sel_y_s  = LIM_LO;
      sel_lo_s = 1'b1;
    end else if (key1_r > KEY_HI) begin
      sel_y_s  = LIM_HI;
      sel_hi_s = 1'b1;
    end else if (key1_r < KEY_LO) begin
      sel_y_s  = LIM_LO;
      sel_lo_s = 1'b1;
    end else begin
      sel_y_s  = x1_r;
    end
  end

  // Stage 2 register.
  always_ff @(posedge clk or posedge rst_user) begin
    if (rst_user) begin
      vld2_r <= 1'b0;
      y2_r   <= {WIDTH{1'b0}};
      hi2_r  <= 1'b0;
      lo2_r  <= 1'b0;
    end else begin
      vld2_r <= vld1_r;
      y2_r   <= sel_y_s;
      hi2_r  <= sel_hi_s;
      lo2_r  <= sel_lo_s;
    end
  end

  assign out_vld = vld2_r;
  assign out_y   = y2_r;
  assign out_hi  = hi2_r;
  assign out_lo  = lo2_r;

endmodule

// File: rtl/pid_out_clamp_frame.sv
// Clamps the time-multiplexed PID output per turbine and assembles it into a channel frame
// with a registered random-access read port, frame completion pulse and saturation flags.
module pid_out_clamp_frame
  import pid_out_clamp_frame_pkg::*;
#(
  parameter int unsigned      WIDTH  = 64,
  parameter int unsigned      N_CH   = 8,
  parameter int unsigned      IDX_W  = 8,
  parameter logic [WIDTH-1:0] LIM_HI = 64'h3FF0_0000_0000_0000,
  parameter logic [WIDTH-1:0] LIM_LO = 64'h0000_0000_0000_0000
) (
  input  logic             clk,
  input  logic             rst_user,
  input  logic             in_ena,
  input  logic [WIDTH-1:0] y_in,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic [IDX_W-1:0] ch_idx,
  output logic             frame_done,
  output logic             sat_hi,
  output logic             sat_lo,
  output logic [15:0]      frame_cnt
);

  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [0:0]  ST_IDLE    = 1'b0;
  localparam logic [0:0]  ST_COLLECT = 1'b1;

  logic             cl_vld_s;
  logic [WIDTH-1:0] cl_y_s;
  logic             cl_hi_s;
  logic             cl_lo_s;
  logic [0:0]       state_r;
  logic [0:0]       state_nx_s;
  logic             first_s;
  logic             last_s;
  logic [IDX_W-1:0] ch_idx_r;
  logic             frame_done_r;
  logic             sat_hi_r;
  logic             sat_lo_r;
  logic [15:0]      frame_cnt_r;
  logic [WIDTH-1:0] rd_data_r;
  logic [WIDTH-1:0] frame_buf_r [N_CH];

  fp64_clamp #(
    .WIDTH  (WIDTH),
    .LIM_HI (LIM_HI),
    .LIM_LO (LIM_LO)
  ) u_clamp (
    .clk      (clk),
    .rst_user (rst_user),
    .in_vld   (in_ena),
    .in_x     (y_in),
    .out_vld  (cl_vld_s),
    .out_y    (cl_y_s),
    .out_hi   (cl_hi_s),
    .out_lo   (cl_lo_s)
  );

  // Frame position decode and next state.
  always_comb begin
    first_s    = (state_r == ST_IDLE);
    last_s     = (ch_idx_r == IDX_W'(N_CH - 1));
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cl_vld_s && !last_s) state_nx_s = ST_COLLECT;
        else                     state_nx_s = ST_IDLE;
      end
      ST_COLLECT: begin
        if (cl_vld_s && last_s) state_nx_s = ST_IDLE;
        else                    state_nx_s = ST_COLLECT;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Channel counter, completion pulse and per-frame sticky flags (cleared by the frame's first write).
  always_ff @(posedge clk or posedge rst_user) begin
    if (rst_user) begin
      state_r      <= ST_IDLE;
      ch_idx_r     <= {IDX_W{1'b0}};
      frame_done_r <= 1'b0;
      sat_hi_r     <= 1'b0;
      sat_lo_r     <= 1'b0;
      frame_cnt_r  <= 16'h0000;
    end else begin
      state_r      <= state_nx_s;
      frame_done_r <= cl_vld_s && last_s;
      if (cl_vld_s) begin
        ch_idx_r <= last_s ? {IDX_W{1'b0}} : ch_idx_r + IDX_W'(1);
        sat_hi_r <= first_s ? cl_hi_s : (sat_hi_r | cl_hi_s);
        sat_lo_r <= first_s ? cl_lo_s : (sat_lo_r | cl_lo_s);
        if (last_s) frame_cnt_r <= frame_cnt_r + 16'd1;
      end
    end
  end

  // Frame buffer write.
  always_ff @(posedge clk or posedge rst_user) begin
    if (rst_user) begin
      for (int i = 0; i < int'(N_CH); i++) frame_buf_r[i] <= {WIDTH{1'b0}};
    end else if (cl_vld_s) begin
      frame_buf_r[ch_idx_r[CH_W-1:0]] <= cl_y_s;
    end
  end

  // Registered read port; reads the pre-write contents, out-of-range addresses return zero.
  always_ff @(posedge clk or posedge rst_user) begin
    if (rst_user) begin
      rd_data_r <= {WIDTH{1'b0}};
    end else if (rd_idx < IDX_W'(N_CH)) begin
      rd_data_r <= frame_buf_r[rd_idx[CH_W-1:0]];
    end else begin
      rd_data_r <= {WIDTH{1'b0}};
    end
  end

  assign rd_data    = rd_data_r;
  assign ch_idx     = ch_idx_r;
  assign frame_done = frame_done_r;
  assign sat_hi     = sat_hi_r;
  assign sat_lo     = sat_lo_r;
  assign frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_pid_out_clamp_frame.sv
// Bench for pid_out_clamp_frame: directed frame sequences, a clamp vector table and randomized
// traffic, all checked every cycle against a real-arithmetic frame model.
module tb_pid_out_clamp_frame;

  localparam logic [63:0] ONE    = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] ZERO   = 64'h0000_0000_0000_0000;
  localparam logic [63:0] HALF   = 64'h3FE0_0000_0000_0000;
  localparam logic [63:0] TWO    = 64'h4000_0000_0000_0000;
  localparam logic [63:0] M3     = 64'hC008_0000_0000_0000;
  localparam logic [63:0] PINF   = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] NINF   = 64'hFFF0_0000_0000_0000;
  localparam logic [63:0] QNAN   = 64'h7FF8_0000_0000_0001;
  localparam logic [63:0] NZERO  = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_user;
  logic        in_ena;
  logic [63:0] y_in;
  logic [7:0]  rd_idx;
  logic [63:0] rd_data;
  logic [7:0]  ch_idx;
  logic        frame_done;
  logic        sat_hi;
  logic        sat_lo;
  logic [15:0] frame_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;
  int tick_no = 0;
  int done_seen = 0;

  pid_out_clamp_frame dut (
    .clk        (clk),
    .rst_user   (rst_user),
    .in_ena     (in_ena),
    .y_in       (y_in),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
    .ch_idx     (ch_idx),
    .frame_done (frame_done),
    .sat_hi     (sat_hi),
    .sat_lo     (sat_lo),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct { bit v; logic [63:0] y; } samp_t;
  samp_t       m_q[$];
  logic [63:0] m_buf [8];
  int          m_ch;
  bit          m_hi, m_lo, m_done;
  int          m_fcnt;
  logic [63:0] m_rd;

  function automatic void clamp_ref(input logic [63:0] y, output logic [63:0] r,
                                    output bit h, output bit l);
    real v;
    v = $bitstoreal(y);
    r = y; h = 1'b0; l = 1'b0;
    if (y[62:52] == 11'h7FF && y[51:0] != 52'h0) begin r = ZERO; l = 1'b1; end
    else if (v > 1.0) begin r = ONE; h = 1'b1; end
    else if (v < 0.0 || y == NZERO) begin r = ZERO; l = 1'b1; end
  endfunction

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < 8; i++) m_buf[i] = ZERO;
    m_ch = 0; m_hi = 1'b0; m_lo = 1'b0; m_done = 1'b0; m_fcnt = 0; m_rd = ZERO;
  endtask

  task automatic model_edge();
    samp_t s;
    logic [63:0] r;
    bit h, l;
    m_rd   = (rd_idx < 8'd8) ? m_buf[rd_idx[2:0]] : ZERO;
    m_done = 1'b0;
    m_q.push_back('{in_ena, y_in});
    if (m_q.size() > 2) begin
      s = m_q.pop_front();
      if (s.v) begin
        clamp_ref(s.y, r, h, l);
        m_buf[m_ch] = r;
        m_hi = (m_ch == 0) ? h : (m_hi | h);
        m_lo = (m_ch == 0) ? l : (m_lo | l);
        if (m_ch == 7) begin m_ch = 0; m_done = 1'b1; m_fcnt = (m_fcnt + 1) % 65536; end
        else m_ch++;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s @tick %0d: got %h, expected %h", name, tick_no, act, exp);
    end
  endtask

  task automatic check_all();
    chk("rd_data", rd_data, m_rd);
    chk("ch_idx", 64'(ch_idx), 64'(m_ch));
    chk("frame_done", 64'(frame_done), 64'(m_done));
    chk("sat_hi", 64'(sat_hi), 64'(m_hi));
    chk("sat_lo", 64'(sat_lo), 64'(m_lo));
    chk("frame_cnt", 64'(frame_cnt), 64'(m_fcnt));
    if (frame_done === 1'b1) done_seen++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    tick_no++;
    check_all();
  endtask

  task automatic drive(input logic e, input logic [63:0] y, input logic [7:0] r);
    in_ena = e; y_in = y; rd_idx = r;
  endtask

  task automatic readback(input logic [63:0] exp [8], input string name);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, ZERO, 8'(i));
      tick();
      chk(name, rd_data, exp[i]);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    chk({name, ".rd_data"}, rd_data, ZERO);
    chk({name, ".ch_idx"}, 64'(ch_idx), 64'h0);
    chk({name, ".frame_done"}, 64'(frame_done), 64'h0);
    chk({name, ".sat"}, 64'({sat_hi, sat_lo}), 64'h0);
    chk({name, ".frame_cnt"}, 64'(frame_cnt), 64'h0);
  endtask

  function automatic logic [63:0] rand_y();
    logic [63:0] sp [6];
    sp = '{TWO, M3, PINF, NINF, QNAN, NZERO};
    case ($urandom_range(0, 4))
      0:       return {$urandom(), $urandom()};
      1:       return {12'h3FE, 20'($urandom()), $urandom()};
      2:       return sp[$urandom_range(0, 5)];
      3:       return {12'hBFE, 20'($urandom()), $urandom()};
      default: return {12'h3FF, 20'($urandom()), $urandom()};
    endcase
  endfunction

  typedef struct { logic [63:0] y; logic [63:0] stored; } cvec_t;
  cvec_t       ctab [8];
  logic [63:0] exp8 [8];
  int          first_pulse, second_pulse, t0;
  bit          found;

  initial begin
    ctab[0] = '{TWO,   ONE};   ctab[1] = '{M3,    ZERO};
    ctab[2] = '{PINF,  ONE};   ctab[3] = '{NINF,  ZERO};
    ctab[4] = '{QNAN,  ZERO};  ctab[5] = '{NZERO, ZERO};
    ctab[6] = '{ONE,   ONE};   ctab[7] = '{ZERO,  ZERO};

    rst_user = 1'b1;
    drive(1'b0, ZERO, 8'd0);
    model_reset();
    #2;
    check_zero_outputs("reset");
    #10 rst_user = 1'b0;

    // In-range burst: 0.5 on every channel; completion 10 cycles after the first sample.
    t0 = tick_no; found = 1'b0; first_pulse = 0;
    for (int i = 0; i < 20; i++) begin
      drive(i < 8, HALF, 8'd9);
      tick();
      if (frame_done === 1'b1 && !found) begin found = 1'b1; first_pulse = tick_no - t0; end
    end
    chk("burst.done_latency", 64'(first_pulse), 64'd10);
    chk("burst.frame_cnt", 64'(frame_cnt), 64'd1);
    chk("burst.sat", 64'({sat_hi, sat_lo}), 64'h0);
    chk("burst.rd_oob", rd_data, ZERO);
    for (int i = 0; i < 8; i++) exp8[i] = HALF;
    readback(exp8, "burst.buf");

    // Clamp table.
    for (int i = 0; i < 8; i++) begin drive(1'b1, ctab[i].y, 8'd0); tick(); end
    for (int i = 0; i < 4; i++) begin drive(1'b0, ZERO, 8'd0); tick(); end
    chk("clamp.sat_hi", 64'(sat_hi), 64'h1);
    chk("clamp.sat_lo", 64'(sat_lo), 64'h1);
    for (int i = 0; i < 8; i++) exp8[i] = ctab[i].stored;
    readback(exp8, "clamp.buf");

    // Split frame: 3 samples, 5-cycle gap, 5 samples.
    done_seen = 0;
    for (int i = 0; i < 18; i++) begin
      if (i < 3)      drive(1'b1, 64'h3FB0_0000_0000_0000 + 64'(i), 8'd0);
      else if (i < 8) drive(1'b0, ZERO, 8'd0);
      else if (i < 13) drive(1'b1, 64'h3FB0_0000_0000_0000 + 64'(i - 5), 8'd0);
      else            drive(1'b0, ZERO, 8'd0);
      tick();
      if (i >= 5 && i <= 7) chk("split.ch_hold", 64'(ch_idx), 64'd3);
    end
    chk("split.done_count", 64'(done_seen), 64'd1);
    for (int i = 0; i < 8; i++) exp8[i] = 64'h3FB0_0000_0000_0000 + 64'(i);
    readback(exp8, "split.buf");

    // Back-to-back frames; frame 1 saturates high, frame 2 is in range and must clear the flags.
    t0 = tick_no; first_pulse = -1; second_pulse = -1;
    for (int i = 0; i < 22; i++) begin
      if (i == 0)       drive(1'b1, TWO, 8'd0);
      else if (i < 16)  drive(1'b1, 64'h3FC0_0000_0000_0000 + 64'(i), 8'd0);
      else              drive(1'b0, ZERO, 8'd0);
      tick();
      if (frame_done === 1'b1) begin
        if (first_pulse < 0) first_pulse = tick_no - t0;
        else second_pulse = tick_no - t0;
      end
    end
    chk("b2b.spacing", 64'(second_pulse - first_pulse), 64'd8);
    chk("b2b.sat", 64'({sat_hi, sat_lo}), 64'h0);
    chk("b2b.frame_cnt", 64'(frame_cnt), 64'd5);
    for (int i = 0; i < 8; i++) exp8[i] = 64'h3FC0_0000_0000_0000 + 64'(i + 8);
    readback(exp8, "b2b.buf");

    // Read/write collision on channel 2: sampled at tick 3, written at tick 5 of this burst.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 64'h3FD0_0000_0000_0000 + 64'(i), 8'd2);
      tick();
      if (i == 4) chk("rdwr.old", rd_data, 64'h3FC0_0000_0000_000A);
      if (i == 5) chk("rdwr.new", rd_data, 64'h3FD0_0000_0000_0002);
    end

    // Reset mid-burst: outputs clear immediately; next burst starts at channel 0.
    for (int i = 0; i < 3; i++) begin drive(1'b1, HALF, 8'd9); tick(); end
    rst_user = 1'b1;
    #1;
    check_zero_outputs("midrst");
    model_reset();
    @(posedge clk);
    #1;
    rst_user = 1'b0;
    for (int i = 0; i < 3; i++) begin drive(1'b1, HALF, 8'd1); tick(); end
    chk("midrst.restart_ch", 64'(ch_idx), 64'd1);

    // Randomized traffic, with one reset partway through.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 9) < 7), rand_y(), 8'($urandom_range(0, 10)));
      if (i == 300) begin
        rst_user = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst_user = 1'b0;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
